// File: rtl/gbe_mon_pkg.sv
// Shared definitions for the 10GbE TX monitor: frame-tracking FSM states
// and the counter saturation limit.
package gbe_mon_pkg;

    localparam int unsigned MIN_CTR_WIDTH = 8;
    localparam int unsigned MAX_CTR_WIDTH = 32;

    // Frame tracking state of the TX stream.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IN_FRAME = 2'd1,
        ST_DROPPING = 2'd2
    } frame_state_e;

    // All-ones value of a counter that is 'width' bits wide, right-aligned.
    function automatic logic [MAX_CTR_WIDTH-1:0] sat_max(input int unsigned width);
        return {MAX_CTR_WIDTH{1'b1}} >> (MAX_CTR_WIDTH - width);
    endfunction

endpackage

// File: rtl/gbe_txof_counter_if.sv
// TX stream signals as seen between the application and the 10GbE core.
// The master drives the stream; the monitor only observes it.
interface gbe_txof_counter_if;

    logic gbe_tx_valid;
    logic gbe_tx_end_of_frame;
    logic gbe_tx_overflow;

    modport master (
        output gbe_tx_valid,
        output gbe_tx_end_of_frame,
        output gbe_tx_overflow
    );

    modport slave (
        input gbe_tx_valid,
        input gbe_tx_end_of_frame,
        input gbe_tx_overflow
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Clear has priority over increment and is honoured even while disabled.
module sat_counter
    import gbe_mon_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(sat_max(WIDTH));

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear first, then a saturating increment.
    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/gbe_txof_counter.sv
// 10GbE TX overflow monitor: counts overflow rising edges, counts frames
// corrupted by an overflow, and keeps a sticky overflow flag. All outputs
// come straight from flops. CTR_WIDTH must lie in 8..32.
module gbe_txof_counter
    import gbe_mon_pkg::*;
#(
    parameter int unsigned CTR_WIDTH       = 32,
    parameter bit          EDGE_DETECT_CLR = 1'b1
) (
    input  logic                     user_clk,
    input  logic                     user_rst_n,
    gbe_txof_counter_if.slave        tx,
    input  logic                     ctr_rst,
    input  logic                     ctr_en,
    output logic [MAX_CTR_WIDTH-1:0] txof_count,
    output logic [MAX_CTR_WIDTH-1:0] txdrop_count,
    output logic                     txof_sticky
);

    logic         of_q;
    logic         ctr_rst_q;
    frame_state_e state_q;
    frame_state_e state_d;
    logic         sticky_q;
    logic         sticky_d;
    logic         drop_inc;

    logic [CTR_WIDTH-1:0] txof_cnt;
    logic [CTR_WIDTH-1:0] txdrop_cnt;

    // The FSM and edge detectors run regardless of ctr_en, so re-enabling
    // while overflow is already high never produces a phantom event.
    wire of_event = tx.gbe_tx_overflow & ~of_q;
    wire eof_word = tx.gbe_tx_valid & tx.gbe_tx_end_of_frame;
    wire clr      = EDGE_DETECT_CLR ? (ctr_rst & ~ctr_rst_q) : ctr_rst;

    // Frame tracking; an overflow on a start or end word marks that frame dropped.
    always_comb begin
        state_d  = state_q;
        drop_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx.gbe_tx_valid && !tx.gbe_tx_end_of_frame) begin
                    state_d = of_event ? ST_DROPPING : ST_IN_FRAME;
                end else if (eof_word && of_event) begin
                    drop_inc = 1'b1;
                end
            end
            ST_IN_FRAME: begin
                if (eof_word) begin
                    state_d  = ST_IDLE;
                    drop_inc = of_event;
                end else if (of_event) begin
                    state_d = ST_DROPPING;
                end
            end
            ST_DROPPING: begin
                if (eof_word) begin
                    state_d  = ST_IDLE;
                    drop_inc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky overflow flag: clear wins, otherwise set on an enabled event.
    always_comb begin
        sticky_d = sticky_q;
        if (clr) begin
            sticky_d = 1'b0;
        end else if (ctr_en && of_event) begin
            sticky_d = 1'b1;
        end
    end

    // Edge-detect history, FSM state and sticky flag.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            of_q      <= 1'b0;
            ctr_rst_q <= 1'b0;
            state_q   <= ST_IDLE;
            sticky_q  <= 1'b0;
        end else begin
            of_q      <= tx.gbe_tx_overflow;
            ctr_rst_q <= ctr_rst;
            state_q   <= state_d;
            sticky_q  <= sticky_d;
        end
    end

    sat_counter #(.WIDTH(CTR_WIDTH)) u_txof_ctr (
        .clk     (user_clk),
        .rst_n   (user_rst_n),
        .clr_i   (clr),
        .en_i    (ctr_en),
        .inc_i   (of_event),
        .count_o (txof_cnt)
    );

    sat_counter #(.WIDTH(CTR_WIDTH)) u_txdrop_ctr (
        .clk     (user_clk),
        .rst_n   (user_rst_n),
        .clr_i   (clr),
        .en_i    (ctr_en),
        .inc_i   (drop_inc),
        .count_o (txdrop_cnt)
    );

    assign txof_count   = MAX_CTR_WIDTH'(txof_cnt);
    assign txdrop_count = MAX_CTR_WIDTH'(txdrop_cnt);
    assign txof_sticky  = sticky_q;

endmodule

// File: doc/gbe_txof_counter.md
GBE_TXOF_COUNTER -- requirements
Module: gbe_txof_counter

Interface
REQ-001 SHALL have parameter CTR_WIDTH, default 32: width of both event counters; legal range 8..32.
REQ-002 SHALL have parameter EDGE_DETECT_CLR, default 1: 1 = clear on rising edge of ctr_rst; 0 = clear while ctr_rst is high.
REQ-003 SHALL have port user_clk, input, 1: the single clock, which is the 10GbE core application clock.
REQ-004 SHALL have port user_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port gbe_tx_valid, input, 1: TX data word presented to the core this cycle.
REQ-006 SHALL have port gbe_tx_end_of_frame, input, 1: last word of the frame; qualified by gbe_tx_valid.
REQ-007 SHALL have port gbe_tx_overflow, input, 1: TX FIFO overflow level from the core.
REQ-008 SHALL have port ctr_rst, input, 1: software counter clear from a ppc2simulink register.
REQ-009 SHALL have port ctr_en, input, 1: counting enable; when low, counters hold.
REQ-010 SHALL have port txof_count, output, 32: overflow event count, zero-extended from CTR_WIDTH; feeds the txofctr simulink2ppc register user_data_in.
REQ-011 SHALL have port txdrop_count, output, 32: count of frames corrupted by overflow, zero-extended.
REQ-012 SHALL have port txof_sticky, output, 1: set on any overflow event; cleared only by a clear or by reset.

Function
REQ-013 SHALL register gbe_tx_overflow into of_q; an overflow event is gbe_tx_overflow=1 and of_q=0.
REQ-014 SHALL increment txof_count on each overflow event when ctr_en=1; the new value is visible on the cycle after the event (1-cycle latency).
REQ-015 SHALL saturate both counters at 2^CTR_WIDTH-1; there is no wrap-around.
REQ-016 SHALL implement a frame FSM with states IDLE, IN_FRAME, DROPPING.
REQ-017 IDLE->IN_FRAME SHALL occur on valid with no EOF; single-word frames (valid and EOF together) SHALL stay in IDLE.
REQ-018 IN_FRAME->IDLE SHALL occur on valid with EOF.
REQ-019 IN_FRAME->DROPPING SHALL occur on an overflow event without EOF.
REQ-020 DROPPING->IDLE SHALL occur on valid with EOF, with txdrop_count incremented once.
REQ-021 An overflow event in IDLE or on an EOF cycle SHALL count the frame ending or starting on that cycle as dropped; at most one drop SHALL be counted per frame.
REQ-022 Further overflow events while DROPPING SHALL increment txof_count only.
REQ-023 A clear (per EDGE_DETECT_CLR) SHALL zero both counters and txof_sticky on the next cycle. Clear wins over a simultaneous increment, giving 0, not 1. The FSM state SHALL be unaffected.
REQ-024 ctr_en=0 SHALL freeze the counters and sticky flag; the FSM and edge detection SHALL still run, so no phantom event is counted when ctr_en is re-enabled while overflow is already high.
REQ-025 All outputs SHALL be driven directly from flops, with no combinational path from input to output.

Reset
REQ-026 While user_rst_n=0: txof_count=0, txdrop_count=0, txof_sticky=0, FSM=IDLE, of_q=0, clear-edge register=0.
REQ-027 If gbe_tx_overflow is high at reset release, that SHALL count as one event on the first clock.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; no drop is counted for it.

Structure
REQ-029 The FSM state enum and the saturation maximum SHALL reside in shared package gbe_mon_pkg.
REQ-030 The saturating counter with clear and enable SHALL be one sub-module, sat_counter, instantiated twice.
REQ-031 Estimated size: 150-250 lines of RTL.

Verification
REQ-032 Reset, then overflow high for 5 cycles -> txof_count=1 one cycle after the rise; txof_sticky=1; txdrop_count=0 (no frame active).
REQ-033 Frame of 8 valid words with an overflow pulse at word 3, EOF at word 8 -> txof_count=1; txdrop_count=1 the cycle after EOF; a following clean frame leaves txdrop_count=1.
REQ-034 CTR_WIDTH=8, 300 overflow pulses -> txof_count=255 and holds.
REQ-035 ctr_rst rising on the same cycle as an overflow event, with txof_count=7 -> txof_count=0 next cycle, not 1; txof_sticky=0.
REQ-036 ctr_en=0, overflow rises and stays high, then ctr_en=1 -> txof_count unchanged; the next fresh rise increments it by 1.
REQ-037 user_rst_n asserted in DROPPING state -> all outputs 0 asynchronously; after release, an EOF with no start counts no drop.
